awg_sample_gearbox: RTL and testbench

- Sits directly downstream of the waveform output stage.
- Accepts 192-bit words (12 x 16-bit samples, sample 0 in bits [15:0]) on a valid/ready handshake and buffers them in a small FIFO.
- Emits them as a continuous 64-bit (4-sample) stream toward the DAC interface, three beats per input word.
- Fills gaps with the idle code and counts underruns once streaming has started.

---
 rtl/awg_sample_gearbox.sv | 120 ++++++++++++
 tb/tb_awg_sample_gearbox.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_sample_gearbox.sv
// Sample gearbox: buffers 192-bit (12-sample) words in a small FIFO and streams
// them out as three 64-bit (4-sample) beats each, padding gaps with an idle code.
module awg_sample_gearbox #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] IDLE_CODE = 16'h7fff
) (
  input  logic                     user_clk,
  input  logic                     rst,
  input  logic                     i_enable,
  input  logic [191:0]             i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [63:0]              o_data,
  output logic                     o_valid,
  input  logic                     i_dac_ready,
  output logic [15:0]              o_underrun_cnt,
  output logic [$clog2(DEPTH):0]   o_fifo_level
);
  localparam int unsigned  PW        = $clog2(DEPTH);
  localparam logic [PW:0]  FULL_LVL  = DEPTH[PW:0];
  localparam logic [63:0]  IDLE_BEAT = {4{IDLE_CODE}};

  typedef enum logic {DISABLED = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  state_t        state_q;
  logic [191:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   level_q, level_d;
  logic [1:0]    phase_q;
  logic          primed_q;
  logic          upend_q;
  logic [15:0]   ucnt_q;
  logic [63:0]   data_q;
  logic          valid_q;

  logic          empty, wr_en, advance, pop;
  logic [191:0]  head;
  logic [63:0]   beat;

  assign empty   = (level_q == '0);
  assign o_ready = i_enable & ~rst & (level_q < FULL_LVL);
  assign wr_en   = i_valid & o_ready;
  assign advance = (state_q == RUN) & (~valid_q | i_dac_ready);
  assign pop     = advance & ~empty & (phase_q == 2'd2);
  assign level_d = level_q + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, pop};
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    beat = head[63:0];
    case (phase_q)
      2'd1:    beat = head[127:64];
      2'd2:    beat = head[191:128];
      default: beat = head[63:0];
    endcase
  end

  // Storage array carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge user_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge user_clk or posedge rst) begin
    if (rst) begin
      state_q  <= DISABLED;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      phase_q  <= '0;
      primed_q <= 1'b0;
      upend_q  <= 1'b0;
      ucnt_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= IDLE_BEAT;
    end else begin
      // Underrun count lags the idle beat that caused it by one cycle.
      if (upend_q) ucnt_q <= sat_inc16(ucnt_q);
      upend_q <= 1'b0;
      if (!i_enable) begin
        state_q  <= DISABLED;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        phase_q  <= '0;
        primed_q <= 1'b0;
        valid_q  <= 1'b0;
        data_q   <= IDLE_BEAT;
      end else begin
        state_q <= RUN;
        level_q <= level_d;
        if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (advance) begin
          valid_q <= 1'b1;
          if (!empty) begin
            data_q   <= beat;
            primed_q <= 1'b1;
            if (phase_q == 2'd2) begin
              phase_q  <= '0;
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end else begin
              phase_q <= phase_q + 2'd1;
            end
          end else begin
            data_q  <= IDLE_BEAT;
            upend_q <= primed_q;
          end
        end
      end
    end
  end

  assign o_data         = data_q;
  assign o_valid        = valid_q;
  assign o_underrun_cnt = ucnt_q;
  assign o_fifo_level   = level_q;

endmodule

// File: tb/tb_awg_sample_gearbox.sv
// Bench for awg_sample_gearbox: cycle table for the first word, then scoreboarded
// streaming, backpressure, disable, saturation and async-reset sequences.
module tb_awg_sample_gearbox;
  localparam logic [63:0] IDLE4 = 64'h7fff7fff7fff7fff;

  logic         user_clk, rst, i_enable, i_valid, i_dac_ready;
  logic [191:0] i_data;
  logic         o_ready, o_valid;
  logic [63:0]  o_data;
  logic [15:0]  o_underrun_cnt;
  logic [2:0]   o_fifo_level;

  awg_sample_gearbox #(.DEPTH(4), .IDLE_CODE(16'h7fff)) dut (
    .user_clk(user_clk), .rst(rst), .i_enable(i_enable), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .i_dac_ready(i_dac_ready), .o_underrun_cnt(o_underrun_cnt),
    .o_fifo_level(o_fifo_level)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  typedef struct {
    logic        en;
    logic        vld;
    logic [15:0] base;
    logic        dac;
    logic        exp_valid;
    logic        exp_ready;
    logic [2:0]  exp_level;
    logic [63:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t        tv [11];
  logic [63:0] sb_q [$];
  int          n_cmp, n_err;
  int          idle_seen, gaps, beats_seen, widx, saved_cnt;
  bit          model_primed, seen_data, done;
  logic [191:0] w;

  function automatic logic [191:0] mkword(input logic [15:0] b);
    logic [191:0] r;
    for (int n = 0; n < 12; n++) r[16*n +: 16] = b + 16'(n);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Output side: compare consumed data beats, observe idle beats; input side: push accepted words.
  task automatic sb_step();
    if (rst) return;
    if (o_valid && o_data == IDLE4) begin
      if (model_primed && i_dac_ready) idle_seen++;
      if (seen_data && sb_q.size() > 0) gaps++;
    end else if (o_valid && i_dac_ready) begin
      if (sb_q.size() == 0) chk("sb_extra", o_data, IDLE4);
      else chk("sb_beat", o_data, sb_q.pop_front());
      seen_data = 1; model_primed = 1; beats_seen++;
    end
    if (i_valid && o_ready)
      for (int k = 0; k < 3; k++) sb_q.push_back(i_data[64*k +: 64]);
  endtask

  task automatic to_neg();   @(negedge user_clk); sb_step(); endtask
  task automatic to_drive(); @(posedge user_clk); #1; endtask
  task automatic cycle();    to_neg(); to_drive(); endtask

  task automatic do_reset();
    rst = 1'b1; i_enable = 1'b0; i_valid = 1'b0;
    sb_q.delete(); idle_seen = 0; model_primed = 0; seen_data = 0;
    to_neg(); to_drive();
    rst = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd0, IDLE4, 16'd0};
    tv[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd0, IDLE4, 16'd0};
    tv[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd0, IDLE4, 16'd0};
    tv[3]  = '{1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 1'b1, 3'd0, IDLE4, 16'd0};
    tv[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd1, IDLE4, 16'd0};
    tv[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd1, 64'h0103_0102_0101_0100, 16'd0};
    tv[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd1, 64'h0107_0106_0105_0104, 16'd0};
    tv[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd0, 64'h010b_010a_0109_0108, 16'd0};
    tv[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd0, IDLE4, 16'd0};
    tv[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd0, IDLE4, 16'd1};
    tv[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd0, IDLE4, 16'd2};

    n_cmp = 0; n_err = 0; idle_seen = 0; gaps = 0; beats_seen = 0;
    model_primed = 0; seen_data = 0;
    rst = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_data = '0; i_dac_ready = 1'b1;

    // Reset state, with i_enable high to show o_ready is masked by rst.
    @(posedge user_clk); #1;
    to_neg();
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, IDLE4);
    chk("rst_level", o_fifo_level, 0);
    chk("rst_cnt", o_underrun_cnt, 0);
    i_enable = 1'b0;
    to_drive();
    rst = 1'b0;

    // Enable, idle stream, then one word with exact latency and underrun timing.
    for (int i = 0; i < 11; i++) begin
      i_enable = tv[i].en; i_valid = tv[i].vld; i_data = mkword(tv[i].base);
      i_dac_ready = tv[i].dac;
      to_neg();
      chk($sformatf("tv%0d_valid", i), o_valid, tv[i].exp_valid);
      chk($sformatf("tv%0d_ready", i), o_ready, tv[i].exp_ready);
      chk($sformatf("tv%0d_level", i), o_fifo_level, tv[i].exp_level);
      chk($sformatf("tv%0d_data", i), o_data, tv[i].exp_data);
      chk($sformatf("tv%0d_cnt", i), o_underrun_cnt, tv[i].exp_cnt);
      to_drive();
    end
    i_valid = 1'b0;

    // Full stream: 8 words back-to-back, must come out gap-free with no underrun.
    do_reset();
    i_enable = 1'b1; i_dac_ready = 1'b1;
    repeat (3) cycle();
    widx = 0; gaps = 0; seen_data = 0; beats_seen = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      i_valid = (widx < 8);
      i_data  = mkword(16'(16'h1000 + widx * 256));
      to_neg();
      if (i_valid && o_ready) widx++;
      if (widx == 8 && sb_q.size() == 0) begin
        done = 1;
        chk("stream_cnt", o_underrun_cnt, 0);
      end
      to_drive();
    end
    i_valid = 1'b0;
    chk("stream_done", done, 1);
    chk("stream_beats", beats_seen, 24);
    chk("stream_gaps", gaps, 0);

    // Backpressure: DAC stalls 10 cycles while beat 1 of the first word is shown.
    repeat (2) cycle();
    w = mkword(16'h2000);
    widx = 0; gaps = 0; seen_data = 0; beats_seen = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      i_dac_ready = !(c >= 3 && c < 13);
      i_valid = (widx < 5);
      i_data  = mkword(16'(16'h2000 + widx * 256));
      to_neg();
      if (c >= 4 && c <= 12) begin
        chk("bp_hold", o_data, w[127:64]);
        chk("bp_level", o_fifo_level, 4);
        chk("bp_ready", o_ready, 0);
      end
      if (i_valid && o_ready) widx++;
      if (widx == 5 && sb_q.size() == 0) done = 1;
      to_drive();
    end
    i_valid = 1'b0; i_dac_ready = 1'b1;
    chk("bp_done", done, 1);
    chk("bp_beats", beats_seen, 15);
    chk("bp_gaps", gaps, 0);

    // Disable with three words buffered at phase 2, then re-enable with a new word.
    repeat (2) cycle();
    chk("pre_dis_cnt", o_underrun_cnt, idle_seen);
    for (int c = 0; c < 7; c++) begin
      i_valid  = (c < 4);
      i_data   = mkword(16'(16'h3000 + c * 256));
      i_enable = (c != 6);
      to_neg();
      if (c == 6) begin
        w = mkword(16'h3100);
        chk("dis_pre_data", o_data, w[127:64]);
        chk("dis_pre_level", o_fifo_level, 3);
      end
      to_drive();
    end
    i_valid = 1'b0;
    sb_q.delete(); model_primed = 0;
    saved_cnt = idle_seen;
    to_neg();
    chk("dis_valid", o_valid, 0);
    chk("dis_level", o_fifo_level, 0);
    chk("dis_data", o_data, IDLE4);
    chk("dis_cnt", o_underrun_cnt, saved_cnt);
    to_drive();
    i_enable = 1'b1; i_valid = 1'b1; i_data = mkword(16'h4000);
    to_neg();
    chk("reen_ready", o_ready, 1);
    to_drive();
    i_valid = 1'b0;
    to_neg();
    chk("reen_valid0", o_valid, 0);
    chk("reen_level", o_fifo_level, 1);
    to_drive();
    to_neg();
    chk("reen_valid1", o_valid, 1);
    chk("reen_first", o_data, 64'h4003_4002_4001_4000);
    to_drive();
    for (int c = 0; c < 50 && sb_q.size() > 0; c++) cycle();
    chk("reen_drained", sb_q.size(), 0);

    // Saturation: stay primed and starved until the counter reaches its ceiling.
    for (int c = 0; c < 70000 && idle_seen < 65534; c++) cycle();
    chk("sat_fffe", o_underrun_cnt, 16'hfffe);
    repeat (3) cycle();
    chk("sat_ffff", o_underrun_cnt, 16'hffff);

    // Async reset between edges while beat 1 of a word is on the output.
    i_valid = 1'b1; i_data = mkword(16'h5000);
    to_neg(); to_drive();
    i_valid = 1'b0;
    cycle();
    to_neg(); to_drive();
    w = mkword(16'h5000);
    chk("arst_pre_data", o_data, w[127:64]);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_data", o_data, IDLE4);
    chk("arst_level", o_fifo_level, 0);
    chk("arst_cnt", o_underrun_cnt, 0);
    chk("arst_ready", o_ready, 0);
    sb_q.delete(); idle_seen = 0; model_primed = 0; seen_data = 0;
    to_neg(); to_drive();
    rst = 1'b0;
    repeat (4) cycle();
    chk("post_valid", o_valid, 1);
    chk("post_data", o_data, IDLE4);
    chk("post_cnt", o_underrun_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
